load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- CPU-side read initiator for the word-organised data memory. This is the load counterpart of the byte/halfword-lane store path.
- Accepts load requests (lb/lbu/lh/lhu/lw) from the execute stage and drives the memory read strobe and word address.
- Waits a parameterised read latency, then extracts and sign- or zero-extends the addressed byte or halfword lane.
- Returns the result with a valid pulse and stalls the pipeline while busy.

Parameters:
- ADDR_W, 7, word-address width driven to memory (128-word array).
- READ_LAT, 1, cycles from mem_rd assertion to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend; ignored for word.
- mem_rd  out  1  memory read enable.
- mem_addr  out  ADDR_W  word address, req_addr[ADDR_W+1:2].
- mem_rdata  in  32  memory read word.
- rsp_valid  out  1  single-cycle pulse, result valid.
- rsp_data  out  32  extended load result.
- rsp_err  out  1  misaligned or reserved-size flag, qualified by rsp_valid.
- busy  out  1  pipeline stall; equals !req_ready.

Behaviour:
- Reset (synchronous, rst high at a clk edge) returns the FSM to IDLE and sets:
  - req_ready = 1, busy = 0;
  - mem_rd = 0, mem_addr = 0;
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0;
  - latency counter = 0.
- Reset asserted mid-operation aborts the load with no response. rst has priority over all other events.
- The request handshake completes on a clk edge with req_valid && req_ready. At that edge the unit latches the lane offset (req_addr[1:0]), req_size, req_signed and mem_addr.
- FSM states and transitions:
  - IDLE: on handshake go to READ.
  - READ: mem_rd = 1, counter counts 0..READ_LAT-1. mem_rd and mem_addr are held stable for the whole state. When the counter reaches READ_LAT-1, capture mem_rdata and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- req_ready is 1 only in IDLE. A request presented in RESP waits; it is accepted no earlier than the cycle after RESP.
- Latency: handshake edge to rsp_valid high = READ_LAT+1 cycles. Throughput is one load per READ_LAT+2 cycles.
- Extraction from the captured word w, with offset o = req_addr[1:0]:
  - Byte: lane o, i.e. o=0 -> w[7:0], o=1 -> w[15:8], o=2 -> w[23:16], o=3 -> w[31:24].
  - Halfword: o[1]=0 -> w[15:0], o[1]=1 -> w[31:16].
  - Word: w unchanged.
  - Sign extension replicates the lane MSB; zero extension fills with 0.
- rsp_data and rsp_err hold their value until the next response. Consumers must qualify them with rsp_valid.
- req_size = 11 produces rsp_err = 1 and rsp_data = 0. The memory read still occurs.
- Addresses wrap modulo 2^ADDR_W words; bits above ADDR_W+1 are ignored.

Optional Feature:
- Macro LOAD_ALIGN_CHECK_EN.
- Defined:
  - halfword with o[0]=1 gives rsp_err = 1, rsp_data = 0;
  - word with o != 0 gives rsp_err = 1, rsp_data = 0;
  - the read still issues and timing is unchanged.
- Undefined:
  - alignment is forced (halfword uses o[1] only; word ignores o);
  - rsp_err is raised only for reserved size.

Decomposition:
- Shared package load_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - FSM state typedef (IDLE, READ, RESP);
  - the lane-offset width constant.
- One combinational sub-module, load_extract: inputs word, offset, size, signed; outputs data and err. It is reused by any future cache-side load path.

Test Plan:
- READ_LAT=1, mem word 0x8899AABB at word address 5:
  - lb at address 0x15 (o=1) -> rsp_data 0xFFFFFFAA, rsp_valid exactly 2 cycles after the handshake;
  - lbu at the same address -> 0x000000AA.
- Same word, lh at address 0x16 -> 0xFFFF8899; lhu -> 0x00008899; lw at 0x14 -> 0x8899AABB with rsp_err = 0.
- READ_LAT=3:
  - mem_rd high for exactly 3 cycles with mem_addr stable, rsp_valid in the 4th cycle;
  - req_ready low throughout, and a back-to-back req_valid is accepted only after RESP.
- rst asserted one cycle into READ -> next cycle all outputs at reset values; no rsp_valid ever appears for the aborted load.
- req_size=11 -> rsp_err = 1, rsp_data = 0.
- lh at address 0x15:
  - with LOAD_ALIGN_CHECK_EN -> rsp_err = 1, rsp_data = 0;
  - without it -> rsp_data = 0xFFFFAABB, rsp_err = 0.

Source files
------------

// File: rtl/load_pkg.sv
// ---------------------------------------------------------------------------
// load_pkg
// Shared definitions for the data-memory load path.
//   - size encodings of a load request (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD)
//   - load FSM state type (IDLE/READ/RESP)
//   - width of the byte-lane offset within a 32-bit word
// Optional feature macro used by the users of this package:
// LOAD_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package load_pkg;

    localparam int OFF_W = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Combinational lane extraction and sign/zero extension for a load.
// Ports:
//   word_i   [31:0]  word read from memory
//   offset_i [1:0]   byte offset of the load address within the word
//   size_i   [1:0]   load size (load_pkg size encoding)
//   signed_i         1 = sign-extend, 0 = zero-extend (ignored for word)
//   data_o   [31:0]  extended result, 0 when err_o is set
//   err_o            reserved size, or misaligned access when checking
// Macro LOAD_ALIGN_CHECK_EN: when defined, misaligned halfword/word loads
// raise err_o; otherwise alignment is forced by ignoring low offset bits.
// ---------------------------------------------------------------------------
module load_extract
    import load_pkg::*;
(
    input  logic [31:0]      word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    output logic [31:0]      data_o,
    output logic             err_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[7:0];
        case (offset_i)
            2'd0: byte_lane = word_i[7:0];
            2'd1: byte_lane = word_i[15:8];
            2'd2: byte_lane = word_i[23:16];
            2'd3: byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
        // Halfword lane is chosen by offset bit 1 only; bit 0 is either
        // ignored or flagged below.
        half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: begin
                data_o = {{16{signed_i & half_lane[15]}}, half_lane};
`ifdef LOAD_ALIGN_CHECK_EN
                if (offset_i[0]) begin
                    data_o = '0;
                    err_o  = 1'b1;
                end
`endif
            end
            SZ_WORD: begin
                data_o = word_i;
`ifdef LOAD_ALIGN_CHECK_EN
                if (offset_i != '0) begin
                    data_o = '0;
                    err_o  = 1'b1;
                end
`endif
            end
            default: begin
                data_o = '0;
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
// CPU-side read initiator for the word-organised data memory. Accepts one
// load at a time, holds the memory read for READ_LAT cycles, extracts and
// extends the addressed lane and returns it with a one-cycle valid pulse.
// Parameters:
//   ADDR_W   word-address width to memory
//   READ_LAT cycles from mem_rd assertion to valid mem_rdata (1..7)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only when idle)
//   req_addr [31:0]     byte address
//   req_size [1:0]      00 byte, 01 half, 10 word, 11 reserved
//   req_signed          sign-extend when set (ignored for word)
//   mem_rd, mem_addr    memory read strobe and word address
//   mem_rdata [31:0]    memory read data
//   rsp_valid           one-cycle result pulse
//   rsp_data, rsp_err   result and error flag, held until next response
//   busy                pipeline stall, inverse of req_ready
// Macro LOAD_ALIGN_CHECK_EN enables misalignment errors in load_extract.
// ---------------------------------------------------------------------------
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [OFF_W-1:0]   off_q;
    logic [1:0]         size_q;
    logic               sgn_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        data_q;
    logic               err_q;

    logic [31:0]        ext_data;
    logic               ext_err;
    logic               handshake;
    logic               capture;

    // Address bits above the word-address range are ignored (wrap-around).
    logic               unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign handshake = req_valid && (state_q == IDLE);
    assign capture   = (state_q == READ) && (cnt_q == LAST_CNT);

    load_extract u_extract (
        .word_i   (mem_rdata),
        .offset_i (off_q),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .data_o   (ext_data),
        .err_o    (ext_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) state_d = READ;
            end
            READ: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake) begin
                off_q  <= req_addr[OFF_W-1:0];
                size_q <= req_size;
                sgn_q  <= req_signed;
                addr_q <= req_addr[ADDR_W+1:2];
            end
            // Extraction runs on the live read word in the last READ cycle,
            // so the registered result is ready exactly when RESP begins.
            if (capture) begin
                data_q <= ext_data;
                err_q  <= ext_err;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign mem_rd    = (state_q == READ);
    assign mem_addr  = addr_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [128];

    // Instance with READ_LAT = 1
    logic        rv1, rr1, rsg1, mrd1, vv1, re1, busy1;
    logic [31:0] ra1, mrdata1, rd1;
    logic [1:0]  rs1;
    logic [6:0]  maddr1;
    logic [3:0]  rdc1;

    // Instance with READ_LAT = 3
    logic        rv3, rr3, rsg3, mrd3, vv3, re3, busy3;
    logic [31:0] ra3, mrdata3, rd3;
    logic [1:0]  rs3;
    logic [6:0]  maddr3;
    logic [3:0]  rdc3;

    logic [32:0] q1[$];
    logic [32:0] q3[$];
    logic [32:0] e1, e3;

    load_unit #(.ADDR_W(7), .READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req_addr(ra1), .req_size(rs1), .req_signed(rsg1),
        .mem_rd(mrd1), .mem_addr(maddr1), .mem_rdata(mrdata1),
        .rsp_valid(vv1), .rsp_data(rd1), .rsp_err(re1), .busy(busy1)
    );

    load_unit #(.ADDR_W(7), .READ_LAT(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3),
        .req_addr(ra3), .req_size(rs3), .req_signed(rsg3),
        .mem_rd(mrd3), .mem_addr(maddr3), .mem_rdata(mrdata3),
        .rsp_valid(vv3), .rsp_data(rd3), .rsp_err(re3), .busy(busy3)
    );

    // Memory models: read data is only valid in the READ_LAT-th cycle of a
    // continuous mem_rd assertion; any other time it is garbage.
    always @(posedge clk) begin
        rdc1 <= mrd1 ? rdc1 + 4'd1 : 4'd0;
        rdc3 <= mrd3 ? rdc3 + 4'd1 : 4'd0;
    end
    assign mrdata1 = (mrd1 && rdc1 == 4'd0) ? mem[maddr1] : 32'hDEADBEEF;
    assign mrdata3 = (mrd3 && rdc3 == 4'd2) ? mem[maddr3] : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference for lane extraction.
    function automatic logic [32:0] ref_ld(input logic [31:0] w, input logic [1:0] o,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] s, r;
        logic        e, align_chk;
`ifdef LOAD_ALIGN_CHECK_EN
        align_chk = 1'b1;
`else
        align_chk = 1'b0;
`endif
        e = 1'b0;
        r = 32'h0;
        case (sz)
            2'd0: begin
                s = w >> (8 * o);
                r = {24'h0, s[7:0]};
                if (sg && s[7]) r = r | 32'hFFFFFF00;
            end
            2'd1: begin
                s = o[1] ? (w >> 16) : w;
                r = {16'h0, s[15:0]};
                if (sg && s[15]) r = r | 32'hFFFF0000;
                if (align_chk && o[0]) e = 1'b1;
            end
            2'd2: begin
                r = w;
                if (align_chk && o != 2'd0) e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        if (e) r = 32'h0;
        return {e, r};
    endfunction

    // Scoreboard: responses popped and compared as the DUTs produce them.
    always @(negedge clk) begin
        if (!rst && vv1) begin
            if (q1.size() == 0) chk("u1_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("u1_rsp_data", rd1, e1[31:0]);
                chk("u1_rsp_err", 32'(re1), 32'(e1[32]));
            end
        end
        if (!rst && vv3) begin
            if (q3.size() == 0) chk("u3_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                chk("u3_rsp_data", rd3, e3[31:0]);
                chk("u3_rsp_err", 32'(re3), 32'(e3[32]));
            end
        end
    end

    // One load on the READ_LAT=1 instance; checks handshake-to-response
    // latency (handshake edge counted as the first) and the single pulse.
    task automatic load1(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rr1), 32'd1);
        rv1 = 1'b1; ra1 = a; rs1 = sz; rsg1 = sg;
        q1.push_back({exp_e, exp_d});
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            rv1 = 1'b0;
        end while (!vv1 && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'd2);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(vv1), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [32:0] r;
        int          n, stray;

        for (int i = 0; i < 128; i++) mem[i] = (32'(i) * 32'h01030507) ^ 32'hA5C30F96;
        mem[5] = 32'h8899AABB;

        rst = 1'b1;
        rv1 = 1'b0; ra1 = '0; rs1 = '0; rsg1 = 1'b0;
        rv3 = 1'b0; ra3 = '0; rs3 = '0; rsg3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(rr1),    32'd1);
        chk("rst_busy",   32'(busy1),  32'd0);
        chk("rst_mem_rd", 32'(mrd1),   32'd0);
        chk("rst_maddr",  32'(maddr1), 32'd0);
        chk("rst_rsp_v",  32'(vv1),    32'd0);
        chk("rst_rsp_d",  rd1,         32'd0);
        chk("rst_rsp_e",  32'(re1),    32'd0);
        chk("rst3_ready", 32'(rr3),    32'd1);
        rst = 1'b0;

        // Directed loads against word 0x8899AABB at word address 5
        load1(32'h15, 2'd0, 1'b1, 32'hFFFFFFAA, 1'b0, "lb_o1");
        load1(32'h15, 2'd0, 1'b0, 32'h000000AA, 1'b0, "lbu_o1");
        load1(32'h17, 2'd0, 1'b1, 32'hFFFFFF88, 1'b0, "lb_o3");
        load1(32'h16, 2'd1, 1'b1, 32'hFFFF8899, 1'b0, "lh_o2");
        load1(32'h16, 2'd1, 1'b0, 32'h00008899, 1'b0, "lhu_o2");
        load1(32'h14, 2'd1, 1'b1, 32'hFFFFAABB, 1'b0, "lh_o0");
        load1(32'h14, 2'd2, 1'b1, 32'h8899AABB, 1'b0, "lw");
        load1(32'h14, 2'd3, 1'b0, 32'h00000000, 1'b1, "rsvd");
`ifdef LOAD_ALIGN_CHECK_EN
        load1(32'h15, 2'd1, 1'b1, 32'h00000000, 1'b1, "lh_mis");
        load1(32'h16, 2'd2, 1'b0, 32'h00000000, 1'b1, "lw_mis");
`else
        load1(32'h15, 2'd1, 1'b1, 32'hFFFFAABB, 1'b0, "lh_mis");
        load1(32'h16, 2'd2, 1'b0, 32'h8899AABB, 1'b0, "lw_mis");
`endif
        load1(32'h80000214, 2'd2, 1'b0, 32'h8899AABB, 1'b0, "lw_wrap");

        for (int i = 0; i < 10; i++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            r  = ref_ld(mem[a[8:2]], a[1:0], sz, sg);
            load1(a, sz, sg, r[31:0], r[32], "rnd");
        end

        // READ_LAT=3: back-to-back requests, second must wait out RESP
        @(negedge clk);
        chk("u3_idle_ready", 32'(rr3), 32'd1);
        rv3 = 1'b1; ra3 = 32'h14; rs3 = 2'd2; rsg3 = 1'b0;
        q3.push_back({1'b0, 32'h8899AABB});
        @(posedge clk);
        @(negedge clk);
        ra3 = 32'h15; rs3 = 2'd0; rsg3 = 1'b0;
        q3.push_back({1'b0, 32'h000000AA});
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            chk("u3_mem_rd",    32'(mrd3),   32'd1);
            chk("u3_mem_addr",  32'(maddr3), 32'd5);
            chk("u3_ready_low", 32'(rr3),    32'd0);
            chk("u3_busy",      32'(busy3),  32'd1);
            chk("u3_no_rsp",    32'(vv3),    32'd0);
        end
        @(negedge clk);
        chk("u3_rsp_4th",     32'(vv3), 32'd1);
        chk("u3_rd_done",     32'(mrd3), 32'd0);
        chk("u3_resp_wait",   32'(rr3), 32'd0);
        @(negedge clk);
        chk("u3_rsp_pulse",   32'(vv3), 32'd0);
        chk("u3_ready_after", 32'(rr3), 32'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        rv3 = 1'b0;
        chk("u3_b_accepted", 32'(mrd3), 32'd1);
        while (!vv3 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("u3_b_latency", 32'(n), 32'd4);

        // Reset one cycle into READ aborts the load with no response
        @(negedge clk);
        @(negedge clk);
        rv3 = 1'b1; ra3 = 32'h16; rs3 = 2'd1; rsg3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv3 = 1'b0;
        chk("abort_in_read", 32'(mrd3), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",  32'(rr3),    32'd1);
        chk("abort_busy",   32'(busy3),  32'd0);
        chk("abort_mem_rd", 32'(mrd3),   32'd0);
        chk("abort_maddr",  32'(maddr3), 32'd0);
        chk("abort_rsp_v",  32'(vv3),    32'd0);
        chk("abort_rsp_d",  rd3,         32'd0);
        chk("abort_rsp_e",  32'(re3),    32'd0);
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vv3) stray++;
        end
        chk("abort_no_rsp", 32'(stray), 32'd0);

        chk("u1_queue_empty", 32'(q1.size()), 32'd0);
        chk("u3_queue_empty", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
